// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM encoding and parity-mode constants for parity_stream.
package parity_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;
endpackage

// File: rtl/parity_stream_if.sv
// parity_stream_if: beat-in / result-out handshake bundle for parity_stream.
interface parity_stream_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_chk;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_error;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  modport master (
    output in_valid, in_data, in_last, in_chk, out_ready,
    input  in_ready, out_valid, out_parity, out_error, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_last, in_chk, out_ready,
    output in_ready, out_valid, out_parity, out_error, out_count, out_ovf
  );
endinterface

// File: rtl/xor_reduce.sv
// xor_reduce: combinational XOR tree folding a WIDTH-bit word to one parity bit.
module xor_reduce #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_in,
  output logic             o_out
);
  assign o_out = ^i_in;
endmodule

// File: rtl/parity_stream.sv
// parity_stream: accumulates XOR parity over a frame of beats and presents
// parity, check error, saturating beat count and overflow at end of frame.
module parity_stream
  import parity_pkg::*;
#(
  parameter int  WIDTH     = 4,
  parameter int  MAX_BEATS = 16,
  parameter bit  ODD_MODE  = PAR_EVEN,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input logic            clk,
  input logic            rst,
  parity_stream_if.slave s
);
  state_t           r_state, w_next;
  logic             r_acc, r_par, r_err, r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             w_bit, w_take, w_sat, w_acc, w_done;
  xor_reduce #(.WIDTH(WIDTH)) u_xor (.i_in(s.in_data), .o_out(w_bit));
  assign w_take = s.in_valid & s.in_ready;
  assign w_sat  = r_cnt == CNT_W'(MAX_BEATS);
  assign w_acc  = r_acc ^ w_bit;
  assign w_done = (r_state == ST_HOLD) & s.out_ready;
  always_ff @(posedge clk)
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  // Unused encoding 2'd3 falls back to IDLE.
  always_comb
    w_next = (r_state == ST_HOLD)  ? (s.out_ready ? ST_IDLE : ST_HOLD) :
             (r_state == ST_IDLE || r_state == ST_ACCUM) ?
               (w_take ? (s.in_last ? ST_HOLD : ST_ACCUM) : r_state) :
             ST_IDLE;
  always_comb begin
    s.in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    s.out_valid = r_state == ST_HOLD;
  end
  // Count and ovf already hold their final values throughout HOLD.
  always_ff @(posedge clk) begin
    if (rst || w_done) begin
      r_acc <= 1'b0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_acc;
      r_cnt <= w_sat ? r_cnt : r_cnt + 1'b1;
      r_ovf <= r_ovf | w_sat;
    end
    if (rst) begin
      r_par <= 1'b0;
      r_err <= 1'b0;
    end else if (w_take && s.in_last) begin
      r_par <= w_acc ^ ODD_MODE;
      r_err <= w_acc ^ ODD_MODE ^ s.in_chk;
    end
  end
  assign s.out_parity = r_par;
  assign s.out_error  = r_err;
  assign s.out_count  = r_cnt;
  assign s.out_ovf    = r_ovf;
endmodule

// File: tb/tb_parity_stream.sv
// tb_parity_stream: directed table plus hand sequences on an even/MAX4 and an
// odd/MAX16 instance, then 1000 random frames on a WIDTH=7 instance.
module tb_parity_stream;
  import parity_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  parity_stream_if #(.WIDTH(4), .CNT_W(3)) a_if ();
  parity_stream_if #(.WIDTH(4), .CNT_W(5)) b_if ();
  parity_stream_if #(.WIDTH(7), .CNT_W(5)) c_if ();
  assign b_if.in_valid  = a_if.in_valid;
  assign b_if.in_data   = a_if.in_data;
  assign b_if.in_last   = a_if.in_last;
  assign b_if.in_chk    = a_if.in_chk;
  assign b_if.out_ready = a_if.out_ready;
  parity_stream #(.WIDTH(4), .MAX_BEATS(4),  .ODD_MODE(PAR_EVEN)) dut_a (.clk(clk), .rst(rst), .s(a_if));
  parity_stream #(.WIDTH(4), .MAX_BEATS(16), .ODD_MODE(PAR_ODD))  dut_b (.clk(clk), .rst(rst), .s(b_if));
  parity_stream #(.WIDTH(7), .MAX_BEATS(16), .ODD_MODE(PAR_EVEN)) dut_c (.clk(clk), .rst(rst), .s(c_if));
  typedef struct {
    int          n;
    logic [23:0] d;
    logic        c;
    logic        pa, ea, oa;
    int          ca;
    logic        pb, eb, ob;
    int          cb;
  } vec_t;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] d, input logic last, input logic ck);
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.in_last  = last;
    a_if.in_chk   = ck;
    chk("beat_ready", 32'(a_if.in_ready), 1);
    tick();
    a_if.in_valid = 1'b0;
  endtask
  task automatic consume();
    a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0;
    chk("after_consume_valid", 32'(a_if.out_valid), 0);
    chk("after_consume_ready", 32'(a_if.in_ready), 1);
  endtask
  task automatic chk_res(input string tag, input logic pa, ea, oa, input int ca,
                         input logic pb, eb, ob, input int cb);
    chk({tag, "_a_valid"},  32'(a_if.out_valid),  1);
    chk({tag, "_a_parity"}, 32'(a_if.out_parity), 32'(pa));
    chk({tag, "_a_error"},  32'(a_if.out_error),  32'(ea));
    chk({tag, "_a_count"},  32'(a_if.out_count),  ca);
    chk({tag, "_a_ovf"},    32'(a_if.out_ovf),    32'(oa));
    chk({tag, "_b_valid"},  32'(b_if.out_valid),  1);
    chk({tag, "_b_parity"}, 32'(b_if.out_parity), 32'(pb));
    chk({tag, "_b_error"},  32'(b_if.out_error),  32'(eb));
    chk({tag, "_b_count"},  32'(b_if.out_count),  cb);
    chk({tag, "_b_ovf"},    32'(b_if.out_ovf),    32'(ob));
  endtask
  vec_t tbl[5];
  initial begin
    logic [3:0] hp;
    logic [6:0] d;
    logic       p, ck;
    int         n;
    tbl[0] = '{3, 24'h000F1B, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 3};
    tbl[1] = '{1, 24'h000006, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1};
    tbl[2] = '{6, 24'h111111, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 6};
    tbl[3] = '{5, 24'h077777, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 5};
    tbl[4] = '{4, 24'h003048, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 4};
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0; a_if.in_chk = 1'b0; a_if.out_ready = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.in_last = 1'b0; c_if.in_chk = 1'b0; c_if.out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  32'(b_if.in_ready),   1);
    chk("rst_valid",     32'(b_if.out_valid),  0);
    chk("rst_parity",    32'(b_if.out_parity), 0);
    chk("rst_error",     32'(b_if.out_error),  0);
    chk("rst_count",     32'(b_if.out_count),  0);
    chk("rst_ovf",       32'(b_if.out_ovf),    0);
    rst = 1'b0;
    tick();
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < tbl[v].n; i++) send(tbl[v].d[4*i +: 4], i == tbl[v].n - 1, tbl[v].c);
      chk_res($sformatf("vec%0d", v), tbl[v].pa, tbl[v].ea, tbl[v].oa, tbl[v].ca,
              tbl[v].pb, tbl[v].eb, tbl[v].ob, tbl[v].cb);
      consume();
    end
    // Back-pressured result: stray beats while held must not disturb anything.
    send(4'b0110, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      a_if.in_valid = k[0];
      a_if.in_data  = 4'b1111;
      a_if.in_last  = 1'b1;
      chk("hold_in_ready", 32'(a_if.in_ready), 0);
      chk_res("hold", 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1);
      tick();
    end
    a_if.in_valid = 1'b0;
    consume();
    send(4'b0001, 1'b1, 1'b0);
    chk_res("post_hold", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1);
    consume();
    // Reset mid-frame discards the partial accumulation.
    send(4'b0001, 1'b0, 1'b0);
    hp = 4'b0011;
    send(hp, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", 32'(a_if.out_count), 0);
    chk("midrst_valid", 32'(a_if.out_valid), 0);
    chk("midrst_ready", 32'(a_if.in_ready),  1);
    send(4'b0001, 1'b1, 1'b0);
    chk_res("after_rst", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1);
    consume();
    // Random frames on the WIDTH=7 instance against a reference XOR model.
    for (int f = 0; f < 1000; f++) begin
      n  = $urandom_range(1, 20);
      ck = 1'($urandom_range(0, 1));
      p  = 1'b0;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          c_if.in_valid = 1'b0;
          c_if.in_data  = 7'($urandom);
          tick();
        end
        d = 7'($urandom);
        p = p ^ (^d);
        c_if.in_valid = 1'b1;
        c_if.in_data  = d;
        c_if.in_last  = i == n - 1;
        c_if.in_chk   = ck;
        chk("rnd_ready", 32'(c_if.in_ready), 1);
        tick();
      end
      c_if.in_valid = 1'b0;
      chk("rnd_valid",  32'(c_if.out_valid),  1);
      chk("rnd_parity", 32'(c_if.out_parity), 32'(p));
      chk("rnd_error",  32'(c_if.out_error),  32'(p ^ ck));
      chk("rnd_count",  32'(c_if.out_count),  n > 16 ? 16 : n);
      chk("rnd_ovf",    32'(c_if.out_ovf),    n > 16 ? 1 : 0);
      repeat ($urandom_range(0, 3)) begin
        c_if.in_valid = 1'($urandom_range(0, 1));
        c_if.in_data  = 7'($urandom);
        tick();
      end
      c_if.in_valid  = 1'b0;
      c_if.out_ready = 1'b1;
      tick();
      c_if.out_ready = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
